// File: rtl/gate_sweep_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_sweep_checker_pkg
// Purpose  : Shared gate function codes, FSM states and sweep constants.
// Revision : 1.0 - initial release
// ============================================================================
package gate_sweep_checker_pkg;

    localparam logic [2:0] FN_NOT   = 3'd0;
    localparam logic [2:0] FN_NOR   = 3'd1;
    localparam logic [2:0] FN_AND   = 3'd2;
    localparam logic [2:0] FN_OR    = 3'd3;
    localparam logic [2:0] FN_XOR   = 3'd4;
    localparam logic [2:0] FN_XNOR  = 3'd5;
    localparam logic [2:0] FN_NAND  = 3'd6;
    localparam logic [2:0] FN_NAND2 = 3'd7;

    localparam int unsigned NUM_VECTORS = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/gate_sweep_checker_golden.sv
`default_nettype none
// ============================================================================
// Module   : gate_golden_model
// Purpose  : Reference output of the universal-gate unit for a given {sel,a,b}.
// Revision : 1.0 - initial release
// ============================================================================
module gate_golden_model
    import gate_sweep_checker_pkg::*;
(
    input  logic [2:0] sel,
    input  logic       a,
    input  logic       b,
    output logic       expected
);

    always_comb begin
        expected = 1'b0;
        case (sel)
            FN_NOT:   expected = ~a;
            FN_NOR:   expected = ~(a | b);
            FN_AND:   expected = a & b;
            FN_OR:    expected = a | b;
            FN_XOR:   expected = a ^ b;
            FN_XNOR:  expected = ~(a ^ b);
            FN_NAND:  expected = ~(a & b);
            FN_NAND2: expected = ~(a & b);
            default:  expected = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/gate_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : gate_sweep_checker
// Purpose  : Sweeps all 32 {sel,a,b} vectors into a gate unit and scores it.
// Revision : 1.0 - initial release
// ============================================================================
module gate_sweep_checker
    import gate_sweep_checker_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_out,
    output logic       a,
    output logic       b,
    output logic [2:0] sel,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] fail_map,
    output logic [5:0] err_count
);

    localparam logic [3:0] C_CNT_RELOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [4:0] C_LAST_IDX   = 5'(NUM_VECTORS - 1);

    state_t     r_state,     w_state;
    logic [4:0] r_idx,       w_idx;
    logic [3:0] r_cnt,       w_cnt;
    logic       r_busy,      w_busy;
    logic       r_done,      w_done;
    logic       r_pass,      w_pass;
    logic [7:0] r_fail_map,  w_fail_map;
    logic [5:0] r_err_count, w_err_count;
    logic       w_expected;

    gate_golden_model u_golden (
        .sel      (r_idx[4:2]),
        .a        (r_idx[1]),
        .b        (r_idx[0]),
        .expected (w_expected)
    );

    always_comb begin
        w_state     = r_state;
        w_idx       = r_idx;
        w_cnt       = r_cnt;
        w_busy      = r_busy;
        w_done      = r_done;
        w_pass      = r_pass;
        w_fail_map  = r_fail_map;
        w_err_count = r_err_count;

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state     = SETTLE;
                    w_idx       = 5'd0;
                    w_cnt       = C_CNT_RELOAD;
                    w_busy      = 1'b1;
                    w_done      = 1'b0;
                    w_pass      = 1'b0;
                    w_fail_map  = 8'h00;
                    w_err_count = 6'd0;
                end
            end
            SETTLE: begin
                if (r_cnt == 4'd0) begin
                    w_state = SAMPLE;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            SAMPLE: begin
                if (dut_out != w_expected) begin
                    w_fail_map[r_idx[4:2]] = 1'b1;
                    w_err_count            = r_err_count + 6'd1;
                end
                if (r_idx == C_LAST_IDX) begin
                    w_state = DONE;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_pass  = (w_err_count == 6'd0);
                end else begin
                    w_idx   = r_idx + 5'd1;
                    w_cnt   = C_CNT_RELOAD;
                    w_state = SETTLE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= 5'd0;
            r_cnt       <= 4'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_map  <= 8'h00;
            r_err_count <= 6'd0;
        end else begin
            r_state     <= w_state;
            r_idx       <= w_idx;
            r_cnt       <= w_cnt;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_pass      <= w_pass;
            r_fail_map  <= w_fail_map;
            r_err_count <= w_err_count;
        end
    end

    // The vector index register directly drives the unit's operands.
    assign sel       = r_idx[4:2];
    assign a         = r_idx[1];
    assign b         = r_idx[0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_map  = r_fail_map;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_sweep_checker
// Purpose  : Scoreboard bench for gate_sweep_checker against emulated gate units.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_sweep_checker;

    localparam int S     = 2;
    localparam int VP    = S + 1;
    localparam int SWEEP = 32 * VP;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       dut_out;
    logic       a, b;
    logic [2:0] sel;
    logic       busy, done, pass;
    logic [7:0] fail_map;
    logic [5:0] err_count;

    always #5 clk = ~clk;

    gate_sweep_checker #(.SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dut_out   (dut_out),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_map  (fail_map),
        .err_count (err_count)
    );

    // Emulated gate unit: a 32-entry truth table indexed by {sel,a,b}.
    logic [31:0] unit_tt;
    always_comb dut_out = unit_tt[{sel, a, b}];

    typedef struct {
        logic [7:0] fm;
        logic [5:0] ec;
        logic       ps;
        int         start_cyc;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    logic [3:0] gold_tt [8];
    logic       prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] golden_unit();
        logic [31:0] u;
        u = '0;
        for (int v = 0; v < 32; v++) u[v] = gold_tt[v / 4][v % 4];
        return u;
    endfunction

    function automatic exp_t predict(input logic [31:0] unit);
        exp_t e;
        e.fm = '0;
        e.ec = '0;
        for (int v = 0; v < 32; v++) begin
            if (unit[v] != gold_tt[v / 4][v % 4]) begin
                e.fm[v / 4] = 1'b1;
                e.ec        = e.ec + 6'd1;
            end
        end
        e.ps        = (e.ec == 0);
        e.start_cyc = 0;
        return e;
    endfunction

    // Monitor: walks the vector sequence of the oldest pending sweep and scores it at done.
    always @(negedge clk) begin : monitor
        int   k;
        exp_t e;
        if (rst_n) begin
            if (q.size() > 0) begin
                k = cyc - q[0].start_cyc - 1;
                if (k >= 0 && k < SWEEP && (k % VP) == 0) begin
                    check("vector", int'({sel, a, b}), k / VP);
                    check("busy_during_sweep", int'(busy), 1);
                end
            end
            if (done && !prev_done) begin
                if (q.size() == 0) begin
                    check("spurious_done", int'(done), 0);
                end else begin
                    e = q.pop_front();
                    check("fail_map", int'(fail_map), int'(e.fm));
                    check("err_count", int'(err_count), int'(e.ec));
                    check("pass", int'(pass), int'(e.ps));
                    check("busy_at_done", int'(busy), 0);
                    check("latency", cyc - e.start_cyc - 1, SWEEP);
                end
            end
        end
        prev_done = done;
    end

    task automatic issue_start();
        exp_t e;
        e           = predict(unit_tt);
        e.start_cyc = cyc;
        q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < SWEEP + 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            check("sweep_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_abs"}, int'({sel, a, b}), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_fail_map"}, int'(fail_map), 0);
        check({tag, "_err_count"}, int'(err_count), 0);
    endtask

    initial begin
        int n;
        gold_tt[0] = 4'b0011;  // ~a, indexed by {a,b}
        gold_tt[1] = 4'b0001;  // nor
        gold_tt[2] = 4'b1000;  // and
        gold_tt[3] = 4'b1110;  // or
        gold_tt[4] = 4'b0110;  // xor
        gold_tt[5] = 4'b1001;  // xnor
        gold_tt[6] = 4'b0111;  // nand
        gold_tt[7] = 4'b0111;  // nand
        rst_n   = 1'b0;
        start   = 1'b0;
        unit_tt = '0;
        repeat (3) @(negedge clk);
        check_reset_state("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Golden unit with ignored start pulses at sweep cycles 10 and 50.
        unit_tt = golden_unit();
        issue_start();
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Output stuck at 0, with start held high across done to force a restart.
        unit_tt = '0;
        issue_start();
        repeat (20) @(negedge clk);
        start = 1'b1;
        n = 0;
        while (!done && n < SWEEP + 50) begin
            @(negedge clk);
            n++;
        end
        check("held_start_reached_done", int'(done), 1);
        begin
            exp_t e;
            e           = predict(unit_tt);
            e.start_cyc = cyc;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        check("restart_done_low", int'(done), 0);
        check("restart_err_cleared", int'(err_count), 0);
        check("restart_map_cleared", int'(fail_map), 0);
        check("restart_busy", int'(busy), 1);
        wait_drain();

        // XNOR returned for sel=4.
        unit_tt = golden_unit();
        for (int ab = 0; ab < 4; ab++) unit_tt[16 + ab] = gold_tt[5][ab];
        issue_start();
        wait_drain();

        // sel=6 and sel=7 swapped: identical functions, so a clean pass.
        unit_tt = golden_unit();
        for (int ab = 0; ab < 4; ab++) begin
            unit_tt[24 + ab] = gold_tt[7][ab];
            unit_tt[28 + ab] = gold_tt[6][ab];
        end
        issue_start();
        wait_drain();

        // Long reset in the middle of a sweep.
        issue_start();
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        q.delete();
        check_reset_state("mid_reset");
        rst_n = 1'b1;
        @(negedge clk);

        // One-cycle reset at idx=10, then a full fresh sweep.
        unit_tt = '0;
        issue_start();
        repeat (30) @(negedge clk);
        check("idx10_reached", int'({sel, a, b}), 10);
        rst_n = 1'b0;
        @(negedge clk);
        q.delete();
        rst_n = 1'b1;
        check("short_reset_idx", int'({sel, a, b}), 0);
        check("short_reset_busy", int'(busy), 0);
        check("short_reset_done", int'(done), 0);
        issue_start();
        wait_drain();

        // Randomised gate units.
        for (int it = 0; it < 6; it++) begin
            case ($urandom_range(0, 2))
                0: unit_tt = $urandom;
                1: begin
                    unit_tt = golden_unit();
                    unit_tt[$urandom_range(0, 31)] ^= 1'b1;
                end
                default: unit_tt = golden_unit();
            endcase
            issue_start();
            wait_drain();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
